// File: rtl/cr_xp10_decomp_htf_pkg.sv
// Shared types and constants for the XP10 Huffman-table code generator.
// Default sizes mirror the top-level parameter defaults. The left-counter
// width helper keeps the Kraft accumulator wide enough for any DEPTH.
package cr_xp10_decomp_htf_pkg;

  localparam int HTF_RANGE_BASE = 1;
  localparam int HTF_DEPTH      = 27;
  localparam int HTF_WIDTH      = 10;
  localparam int HTF_SYM_W      = 10;

  // Two extra bits: one for growth (left can reach 2^DEPTH), one for sign.
  function automatic int htf_left_w(input int depth);
    return depth + 2;
  endfunction

  localparam int HTF_LEFT_W = htf_left_w(HTF_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WALK = 2'd1,
    ST_DONE = 2'd2
  } htf_state_e;

  typedef logic [HTF_DEPTH-1:0][HTF_WIDTH-1:0] htf_count_vec_t;
  typedef logic [HTF_DEPTH-1:0][HTF_DEPTH-1:0] htf_code_vec_t;
  typedef logic [HTF_DEPTH-1:0][HTF_SYM_W-1:0] htf_base_vec_t;

endpackage

// File: rtl/cr_xp10_decomp_htf_kraft_step.sv
// One canonical-Huffman step for a single code length: advances the first
// code, the cumulative symbol base and the Kraft "codes left" counter.
module cr_xp10_decomp_htf_kraft_step #(
  parameter int DEPTH  = 27,
  parameter int WIDTH  = 10,
  parameter int SYM_W  = 10,
  parameter int LEFT_W = DEPTH + 2
) (
  input  logic        [DEPTH-1:0]  code,
  input  logic        [SYM_W-1:0]  base,
  input  logic signed [LEFT_W-1:0] left,
  input  logic        [WIDTH-1:0]  count,
  output logic        [DEPTH-1:0]  code_nxt,
  output logic        [SYM_W-1:0]  base_nxt,
  output logic signed [LEFT_W-1:0] left_nxt,
  output logic                     neg
);

  logic        [DEPTH-1:0]  code_sum;
  logic signed [LEFT_W-1:0] count_s;

  // Next code/base/left; a negative left means the lengths are oversubscribed.
  always_comb begin
    code_sum = code + DEPTH'(count);
    code_nxt = code_sum << 1;
    base_nxt = base + SYM_W'(count);
    count_s  = $signed({{(LEFT_W-WIDTH){1'b0}}, count});
    left_nxt = (left <<< 1) - count_s;
    neg      = left_nxt[LEFT_W-1];
  end

endmodule

// File: rtl/cr_xp10_decomp_htf_code_gen.sv
// Canonical Huffman first-code / symbol-base generator with Kraft check.
// Snapshots the length histogram on start, walks one length per cycle and
// reports tbl_valid / oversub / incomplete / empty with a done pulse.
// Optional macro CR_XP10_DECOMP_HTF_SINGLE_CODE_EN: a lone length-RANGE_BASE
// code with count 1 is accepted as a valid single-symbol table.
module cr_xp10_decomp_htf_code_gen
  import cr_xp10_decomp_htf_pkg::*;
#(
  parameter int RANGE_BASE = HTF_RANGE_BASE,
  parameter int DEPTH      = HTF_DEPTH,
  parameter int WIDTH      = HTF_WIDTH,
  parameter int SYM_W      = HTF_SYM_W
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [DEPTH-1:0][WIDTH-1:0]  bl_count,
  output logic                         busy,
  output logic                         done,
  output logic                         tbl_valid,
  output logic                         oversub,
  output logic                         incomplete,
  output logic                         empty,
  output logic [DEPTH-1:0][DEPTH-1:0]  first_code,
  output logic [DEPTH-1:0][SYM_W-1:0]  sym_base,
  output logic [SYM_W-1:0]             num_syms
);

  localparam int LEFT_W = htf_left_w(DEPTH);
  localparam int LEN_W  = $clog2(DEPTH + RANGE_BASE + 1);
  localparam logic [LEN_W-1:0] LEN_FIRST = LEN_W'(RANGE_BASE);
  localparam logic [LEN_W-1:0] LEN_LAST  = LEN_W'(DEPTH + RANGE_BASE - 1);

  htf_state_e                  state_q;
  logic [DEPTH-1:0][WIDTH-1:0] snap_q;
  logic [LEN_W-1:0]            len_q;
  logic [LEN_W-1:0]            slot;
  logic [DEPTH-1:0]            code_q;
  logic [SYM_W-1:0]            base_q;
  logic signed [LEFT_W-1:0]    left_q;

  logic [DEPTH-1:0]            code_nxt;
  logic [SYM_W-1:0]            base_nxt;
  logic signed [LEFT_W-1:0]    left_nxt;
  logic                        left_neg;
  logic                        single_code;
  logic                        fin_valid;
  logic                        fin_incomplete;
  logic                        fin_empty;

  assign busy = (state_q != ST_IDLE);
  assign slot = len_q - LEN_FIRST;

  cr_xp10_decomp_htf_kraft_step #(
    .DEPTH  (DEPTH),
    .WIDTH  (WIDTH),
    .SYM_W  (SYM_W),
    .LEFT_W (LEFT_W)
  ) u_step (
    .code     (code_q),
    .base     (base_q),
    .left     (left_q),
    .count    (snap_q[slot]),
    .code_nxt (code_nxt),
    .base_nxt (base_nxt),
    .left_nxt (left_nxt),
    .neg      (left_neg)
  );

  // Detect the lone "one code of the shortest length" histogram.
  always_comb begin
    single_code = 1'b0;
`ifdef CR_XP10_DECOMP_HTF_SINGLE_CODE_EN
    single_code = (snap_q[0] == WIDTH'(1)) && ((snap_q >> WIDTH) == '0);
`endif
  end

  // Final status from the values produced by the last length step.
  always_comb begin
    fin_valid      = 1'b0;
    fin_incomplete = 1'b0;
    fin_empty      = 1'b0;
    if (base_nxt == '0) begin
      fin_empty = 1'b1;
    end else if (!left_neg && (left_nxt != '0)) begin
      if (single_code) fin_valid      = 1'b1;
      else             fin_incomplete = 1'b1;
    end else begin
      fin_valid = 1'b1;
    end
  end

  // FSM, histogram snapshot, walk registers and held status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      snap_q     <= '0;
      len_q      <= '0;
      code_q     <= '0;
      base_q     <= '0;
      left_q     <= '0;
      done       <= 1'b0;
      tbl_valid  <= 1'b0;
      oversub    <= 1'b0;
      incomplete <= 1'b0;
      empty      <= 1'b0;
      first_code <= '0;
      sym_base   <= '0;
      num_syms   <= '0;
    end else begin
      done <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            snap_q     <= bl_count;
            len_q      <= LEN_FIRST;
            code_q     <= '0;
            base_q     <= '0;
            left_q     <= {{(LEFT_W-1){1'b0}}, 1'b1};
            tbl_valid  <= 1'b0;
            oversub    <= 1'b0;
            incomplete <= 1'b0;
            empty      <= 1'b0;
            first_code <= '0;
            sym_base   <= '0;
            num_syms   <= '0;
            state_q    <= ST_WALK;
          end
        end
        ST_WALK: begin
          first_code[slot] <= code_q;
          sym_base[slot]   <= base_q;
          code_q           <= code_nxt;
          base_q           <= base_nxt;
          left_q           <= left_nxt;
          len_q            <= len_q + 1'b1;
          if (left_neg) begin
            oversub  <= 1'b1;
            num_syms <= base_nxt;
            done     <= 1'b1;
            state_q  <= ST_DONE;
          end else if (len_q == LEN_LAST) begin
            tbl_valid  <= fin_valid;
            incomplete <= fin_incomplete;
            empty      <= fin_empty;
            num_syms   <= base_nxt;
            done       <= 1'b1;
            state_q    <= ST_DONE;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cr_xp10_decomp_htf_code_gen.sv
// Directed bench for the canonical Huffman code generator.
module tb_cr_xp10_decomp_htf_code_gen;

  localparam int DEPTH = 27;
  localparam int WIDTH = 10;
  localparam int SYM_W = 10;

  logic                        clk;
  logic                        rst_n;
  logic                        start;
  logic [DEPTH-1:0][WIDTH-1:0] bl_count;
  logic                        busy;
  logic                        done;
  logic                        tbl_valid;
  logic                        oversub;
  logic                        incomplete;
  logic                        empty;
  logic [DEPTH-1:0][DEPTH-1:0] first_code;
  logic [DEPTH-1:0][SYM_W-1:0] sym_base;
  logic [SYM_W-1:0]            num_syms;

  int n_vec;
  int n_bad;

  cr_xp10_decomp_htf_code_gen dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .bl_count   (bl_count),
    .busy       (busy),
    .done       (done),
    .tbl_valid  (tbl_valid),
    .oversub    (oversub),
    .incomplete (incomplete),
    .empty      (empty),
    .first_code (first_code),
    .sym_base   (sym_base),
    .num_syms   (num_syms)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // bl_count index i holds the count for code length i+1.
  task automatic set_canonical();
    bl_count    = '0;
    bl_count[1] = 10'd1;
    bl_count[2] = 10'd5;
    bl_count[3] = 10'd2;
  endtask

  // Pulse start for one cycle and count cycles until done (bounded).
  task automatic run_walk(output int lat, output bit seen);
    lat  = 0;
    seen = 1'b0;
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 60 && !seen; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        lat  = c;
        seen = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    start    = 1'b0;
    bl_count = '0;
    #1;
    n_vec++;
    if ({busy, done, tbl_valid, oversub, incomplete, empty} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_flags: got %b want 000000",
               {busy, done, tbl_valid, oversub, incomplete, empty});
    end
    n_vec++;
    if (first_code !== '0 || sym_base !== '0 || num_syms !== '0) begin
      n_bad++;
      $display("FAIL reset_data: num_syms got %0d want 0", num_syms);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_canonical();
    int lat;
    bit seen;
    set_canonical();
    run_walk(lat, seen);
    n_vec++;
    if (!seen || lat != 28) begin
      n_bad++;
      $display("FAIL canon_latency: got %0d (seen=%0d) want 28", lat, seen);
    end
    n_vec++;
    if (first_code[1] !== 27'd0 || first_code[2] !== 27'd2 ||
        first_code[3] !== 27'd14 || first_code[4] !== 27'd32) begin
      n_bad++;
      $display("FAIL canon_first_code: got %0d %0d %0d %0d want 0 2 14 32",
               first_code[1], first_code[2], first_code[3], first_code[4]);
    end
    n_vec++;
    if (sym_base[1] !== 10'd0 || sym_base[2] !== 10'd1 || sym_base[3] !== 10'd6) begin
      n_bad++;
      $display("FAIL canon_sym_base: got %0d %0d %0d want 0 1 6",
               sym_base[1], sym_base[2], sym_base[3]);
    end
    n_vec++;
    if (num_syms !== 10'd8) begin
      n_bad++;
      $display("FAIL canon_num_syms: got %0d want 8", num_syms);
    end
    n_vec++;
    if ({tbl_valid, oversub, incomplete, empty} !== 4'b1000) begin
      n_bad++;
      $display("FAIL canon_status: got %b want 1000",
               {tbl_valid, oversub, incomplete, empty});
    end
    @(negedge clk);
    n_vec++;
    if ({busy, done, tbl_valid} !== 3'b001) begin
      n_bad++;
      $display("FAIL canon_after_done: got busy/done/valid %b want 001",
               {busy, done, tbl_valid});
    end
  endtask

  task automatic test_back_to_back();
    int  lat;
    bit  seen;
    set_canonical();
    lat  = 0;
    seen = 1'b0;
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 60 && !seen; c++) begin
      @(negedge clk);
      start = (c >= 3 && c <= 20);
      if (c == 1) bl_count = {DEPTH{10'd1}};
      if (c == 5) begin
        n_vec++;
        if ({busy, tbl_valid} !== 2'b10) begin
          n_bad++;
          $display("FAIL b2b_walk_state: got busy/valid %b want 10", {busy, tbl_valid});
        end
      end
      if (done) begin
        lat  = c;
        seen = 1'b1;
      end
    end
    start = 1'b0;
    n_vec++;
    if (!seen || lat != 28) begin
      n_bad++;
      $display("FAIL b2b_latency: got %0d (seen=%0d) want 28", lat, seen);
    end
    n_vec++;
    if (first_code[3] !== 27'd14 || sym_base[3] !== 10'd6 || num_syms !== 10'd8 ||
        tbl_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_snapshot: got fc4=%0d sb4=%0d n=%0d v=%0d want 14 6 8 1",
               first_code[3], sym_base[3], num_syms, tbl_valid);
    end
    @(negedge clk);
  endtask

  task automatic test_oversub();
    int lat;
    bit seen;
    bl_count    = '0;
    bl_count[0] = 10'd3;
    run_walk(lat, seen);
    n_vec++;
    if (!seen || lat != 2) begin
      n_bad++;
      $display("FAIL oversub_latency: got %0d (seen=%0d) want 2", lat, seen);
    end
    n_vec++;
    if ({tbl_valid, oversub, incomplete, empty} !== 4'b0100) begin
      n_bad++;
      $display("FAIL oversub_status: got %b want 0100",
               {tbl_valid, oversub, incomplete, empty});
    end
    n_vec++;
    if (first_code !== '0 || sym_base !== '0) begin
      n_bad++;
      $display("FAIL oversub_tables: got fc2=%0d sb2=%0d want all zero",
               first_code[1], sym_base[1]);
    end
    @(negedge clk);
  endtask

  task automatic test_single();
    int lat;
    bit seen;
    logic [3:0] exp_st;
`ifdef CR_XP10_DECOMP_HTF_SINGLE_CODE_EN
    exp_st = 4'b1000;
`else
    exp_st = 4'b0010;
`endif
    bl_count    = '0;
    bl_count[0] = 10'd1;
    run_walk(lat, seen);
    n_vec++;
    if (!seen || lat != 28) begin
      n_bad++;
      $display("FAIL single_latency: got %0d (seen=%0d) want 28", lat, seen);
    end
    n_vec++;
    if ({tbl_valid, oversub, incomplete, empty} !== exp_st || num_syms !== 10'd1) begin
      n_bad++;
      $display("FAIL single_status: got %b n=%0d want %b n=1",
               {tbl_valid, oversub, incomplete, empty}, num_syms, exp_st);
    end
    @(negedge clk);
  endtask

  task automatic test_empty();
    int lat;
    bit seen;
    bl_count = '0;
    run_walk(lat, seen);
    n_vec++;
    if (!seen || lat != 28) begin
      n_bad++;
      $display("FAIL empty_latency: got %0d (seen=%0d) want 28", lat, seen);
    end
    n_vec++;
    if ({tbl_valid, oversub, incomplete, empty} !== 4'b0001 || num_syms !== 10'd0) begin
      n_bad++;
      $display("FAIL empty_status: got %b n=%0d want 0001 n=0",
               {tbl_valid, oversub, incomplete, empty}, num_syms);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_walk();
    int lat;
    bit seen;
    bit stray;
    set_canonical();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({busy, done, tbl_valid, oversub, incomplete, empty} !== 6'b0 ||
        first_code !== '0 || sym_base !== '0 || num_syms !== '0) begin
      n_bad++;
      $display("FAIL midreset_clear: got flags %b fc3=%0d want all zero",
               {busy, done, tbl_valid, oversub, incomplete, empty}, first_code[2]);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    stray = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (done || busy) stray = 1'b1;
    end
    n_vec++;
    if (stray !== 1'b0) begin
      n_bad++;
      $display("FAIL midreset_no_done: got stray activity %0d want 0", stray);
    end
    run_walk(lat, seen);
    n_vec++;
    if (!seen || lat != 28 || tbl_valid !== 1'b1 || first_code[3] !== 27'd14) begin
      n_bad++;
      $display("FAIL midreset_rerun: got lat=%0d v=%0d fc4=%0d want 28 1 14",
               lat, tbl_valid, first_code[3]);
    end
    @(negedge clk);
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    test_reset();
    test_canonical();
    test_back_to_back();
    test_oversub();
    test_single();
    test_empty();
    test_reset_mid_walk();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/cr_xp10_decomp_htf_code_gen.md
Name: cr_xp10_decomp_htf_code_gen

Overview:
Downstream of the Huffman-table-formation length histogram (per-length code counts, lengths RANGE_BASE..DEPTH+RANGE_BASE-1). On a start pulse it snapshots the histogram, then walks one length per cycle. For each length it computes the canonical first code, the cumulative symbol base and a Kraft-sum validity check. It raises done with oversubscribed/incomplete status for the table-build and decode-LUT fill stages.

Parameters:
RANGE_BASE, 1, lowest code length index; count at length 0 is never presented.
DEPTH, 27, number of lengths tracked; also the maximum code width in bits.
WIDTH, 10, width of each per-length count.
SYM_W, 10, width of cumulative symbol base and total-symbol outputs.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle request to process bl_count; honoured only in IDLE
bl_count  in  DEPTH x WIDTH (index RANGE_BASE..)  per-length code counts
busy  out  1  high when state != IDLE
done  out  1  one-cycle pulse, walk finished or aborted
tbl_valid  out  1  first_code/sym_base valid and tree complete; held until next accepted start
oversub  out  1  Kraft sum > 1; held until next accepted start
incomplete  out  1  Kraft sum < 1 (non-empty); held until next accepted start
empty  out  1  all counts zero; held until next accepted start
first_code  out  DEPTH x DEPTH  canonical first code per length
sym_base  out  DEPTH x SYM_W  count of symbols with shorter length
num_syms  out  SYM_W  total of all counts

Behaviour:
- Clock and reset: single clock clk. rst_n is asynchronous, active-low.
- Reset state: IDLE; every output and internal register is 0.
- Reset asserted mid-walk: abort immediately to IDLE with all outputs 0; no done pulse.
- States: IDLE -> WALK on start. WALK -> DONE after length DEPTH+RANGE_BASE-1, or early on oversubscription. DONE -> IDLE unconditionally.
- start is ignored in WALK and DONE. There is no queueing.
- Cycle T (IDLE, start=1):
  - snapshot bl_count into an internal register;
  - clear tbl_valid, oversub, incomplete, empty, num_syms, first_code, sym_base;
  - init code=0, base=0, left=1.
- Cycles T+1..T+DEPTH (WALK), processing length L = RANGE_BASE + k:
  - first_code[L] = code; sym_base[L] = base;
  - left = 2*left - count[L];
  - code = (code + count[L]) << 1, truncated to DEPTH bits;
  - base += count[L], truncated to SYM_W bits.
- Arithmetic: left is a signed register of DEPTH+2 bits. count is zero-extended.
- Early abort: if the updated left < 0, set oversub and go to DONE next cycle. first_code/sym_base for unprocessed lengths stay 0.
- Normal end: done pulses in cycle T+DEPTH+1; total latency start-to-done = DEPTH+1 cycles.
- In DONE: num_syms = base.
  - base == 0: empty=1, tbl_valid=0.
  - else left > 0: incomplete=1, tbl_valid=0.
  - else left == 0: tbl_valid=1.
- Status flags are mutually exclusive.
- Changes to bl_count after cycle T have no effect.

Optional Feature:
- Macro: CR_XP10_DECOMP_HTF_SINGLE_CODE_EN.
- Defined: a histogram with exactly one nonzero count, count[RANGE_BASE]==1, is reported as tbl_valid=1, incomplete=0 (single-symbol code of length 1).
- Undefined: that case reports incomplete=1, tbl_valid=0.
- No other behaviour changes.

Decomposition:
- Package cr_xp10_decomp_htf_pkg holds:
  - state enum {IDLE, WALK, DONE};
  - localparam for the left-counter width (DEPTH+2);
  - typedefs for the count, code and base vectors.
- One natural sub-module, cr_xp10_decomp_htf_kraft_step: combinational per-length step with inputs code, base, left, count and outputs next values plus neg flag. The top holds the FSM, the length counter and the registers.

Test Plan:
- count[2]=1, count[3]=5, count[4]=2, rest 0 (DEPTH=27):
  - first_code[2]=0, [3]=2, [4]=14; sym_base[2]=0, [3]=1, [4]=6; num_syms=8;
  - tbl_valid=1; done exactly 28 cycles after start.
- count[1]=3 -> oversub=1, tbl_valid=0; done 2 cycles after start; first_code[2..] all 0.
- count[1]=1 only -> incomplete=1 (macro off); tbl_valid=1, incomplete=0 (macro on).
- All counts 0 -> empty=1, num_syms=0, tbl_valid=0.
- start repeated during WALK, plus bl_count changed after start -> no restart; results match the snapshot.
- rst_n low at cycle 10 of a walk -> immediate IDLE, outputs 0, no done; a later start completes normally.
